fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two in 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_resp_valid  input  1  instruction word returned (in request order, latency >= 1 cycle).
REQ-009 imem_resp_data  input  32  returned instruction word.
REQ-010 redirect  input  1  taken branch/jump from MEM stage (PCSrc_M).
REQ-011 redirect_pc  input  32  redirect target (PCTarget_M).
REQ-012 deq_ready  input  1  IF/ID register consumes instruction this cycle.
REQ-013 deq_valid  output  1  head instruction available.
REQ-014 deq_instr  output  32  head instruction (Instr_F).
REQ-015 deq_pc  output  32  PC of head instruction (PC_F).

Function
REQ-016 Fetch PC register fpc SHALL drive imem_req_addr; on request handshake (imem_req_valid & imem_req_ready) fpc SHALL advance by 4, wrapping modulo 2^32.
REQ-017 Each handshake SHALL reserve the tail entry, recording fpc as its PC, with filled flag clear.
REQ-018 Occupancy = reserved entries (filled or not); imem_req_valid SHALL be 1 only when occupancy < DEPTH, redirect = 0 and reset = 0.
REQ-019 Full check SHALL use registered occupancy; a pop in the same cycle does not enable a request.
REQ-020 imem_req_valid SHALL NOT fall while imem_req_ready = 0 except on redirect or reset.
REQ-021 A response with drop counter = 0 SHALL write imem_resp_data into the oldest reserved unfilled entry and set its filled flag.
REQ-022 deq_valid SHALL equal the head entry's filled flag, forced to 0 in any redirect cycle; deq_instr/deq_pc SHALL show head contents.
REQ-023 Pop (deq_valid & deq_ready) SHALL free the head entry; head/tail pointers wrap modulo DEPTH.
REQ-024 Simultaneous request, response and pop in one cycle SHALL all take effect; a response to the head entry makes it visible the next cycle (no combinational bypass).
REQ-025 Redirect SHALL, at the clock edge: invalidate all entries, set fpc to {redirect_pc[31:2],2'b00}, and set drop counter to the number of accepted-but-unanswered requests, not counting one answered in the redirect cycle.
REQ-026 A response arriving in the redirect cycle SHALL be discarded.
REQ-027 While drop counter > 0, each response SHALL be discarded and decrement the counter; new requests after redirect SHALL be allowed while draining.
REQ-028 A response with no reserved unfilled entry and drop counter = 0 SHALL be ignored with no state change.
REQ-029 Minimum latency: request accepted cycle N, response cycle N+1, deq_valid = 1 cycle N+2.
REQ-030 Sustained throughput with 1-cycle memory and deq_ready = 1 SHALL be one instruction per cycle once DEPTH >= 2.

Reset
REQ-031 During reset cycle: fpc <= RESET_PC, all filled/reserved flags cleared, pointers and drop counter <= 0.
REQ-032 Outputs during and immediately after reset: imem_req_valid 0 in reset cycle, deq_valid 0, deq_instr 0, deq_pc 0 until first fill.
REQ-033 Reset mid-operation SHALL discard in-flight responses' effect only via the protocol assumption that memory is reset simultaneously.

Verification
REQ-034 Reset, 1-cycle memory, deq_ready=1 -> addresses 0x0,0x4,0x8,... consecutive cycles; deq_pc 0x0 first at cycle 2 after reset release, then one per cycle.
REQ-035 deq_ready=0 held, DEPTH=4 -> exactly 4 handshakes (0x0..0xC), imem_req_valid 0 thereafter; releasing deq_ready resumes with 0x10 one cycle after first pop.
REQ-036 3-cycle memory, 3 requests outstanding, redirect to 0x103 -> next request address 0x100, 3 stale responses discarded, first deq_pc 0x100 with its correct word.
REQ-037 Redirect in same cycle as response and pop -> response discarded, no pop observed (deq_valid 0), drop counter excludes that response.
REQ-038 fpc = 0xFFFF_FFFC accepted -> next address 0x0000_0000; spurious imem_resp_valid with queue empty -> no deq_valid.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches, buffers returned
// instructions with their PCs, and flushes/drains cleanly on a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq_ready,
  output logic        deq_valid,
  output logic [31:0] deq_instr,
  output logic [31:0] deq_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  // Stale responses can pile up across back-to-back redirects, so the drop
  // counter is wider than the occupancy counter.
  localparam int unsigned DW = 8;

  logic [31:0]       fpc_q, fpc_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     pend_q, pend_d;
  logic [DW-1:0]     drop_q, drop_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [31:0]       pc_mem_q    [DEPTH];
  logic [31:0]       pc_mem_d    [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];

  logic              req_fire;
  logic              pop;
  logic              resp_fill;
  logic              head_filled;
  logic [DW-1:0]     outstanding;

  assign imem_req_valid = ~reset & ~redirect & (count_q < CW'(DEPTH));
  assign imem_req_addr  = fpc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign head_filled = filled_q[head_q];
  assign deq_valid   = head_filled & ~redirect & ~reset;
  // Payload is masked until the head is filled so nothing stale leaks out.
  assign deq_instr   = head_filled ? instr_mem_q[head_q] : 32'h0;
  assign deq_pc      = head_filled ? pc_mem_q[head_q]    : 32'h0;
  assign pop         = deq_valid & deq_ready;

  assign resp_fill   = imem_resp_valid & ~redirect & (drop_q == '0) & (pend_q != '0);
  assign outstanding = drop_q + DW'(pend_q);

  // NOTE: every signal gets its default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    fpc_d       = fpc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    fill_d      = fill_q;
    count_d     = count_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect) begin
      fpc_d    = {redirect_pc[31:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      filled_d = '0;
      // A response landing this cycle answers the oldest outstanding request.
      drop_d   = (imem_resp_valid && outstanding != '0) ? outstanding - DW'(1) : outstanding;
    end else begin
      if (req_fire) begin
        pc_mem_d[tail_q] = fpc_q;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
        fpc_d            = fpc_q + 32'd4;
      end

      if (imem_resp_valid && drop_q != '0) begin
        drop_d = drop_q - DW'(1);
      end else if (resp_fill) begin
        instr_mem_d[fill_q] = imem_resp_data;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + PW'(1);
      end

      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end

      count_d = count_q + CW'(req_fire) - CW'(pop);
      pend_d  = pend_q + CW'(req_fire) - CW'(resp_fill);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // NOTE: payload storage is not reset; the filled flags alone decide what is visible.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue with an in-order memory
// model and a (pc, instr) scoreboard checked at every dequeue.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .deq_ready       (deq_ready),
    .deq_valid       (deq_valid),
    .deq_instr       (deq_instr),
    .deq_pc          (deq_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t        sb[$];
  mreq_t       mq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          lat;
  int          last_due;
  int          hs_cnt;
  int          pop_cnt;
  int          first_pop_cyc;
  int          last_hs_cyc;
  int          base;
  logic [31:0] first_pop_pc;
  logic [31:0] exp_pc;
  logic        spurious;
  logic        prev_stall;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1234};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    deq_ready       = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    spurious        = 1'b0;
    lat             = 1;
    mq.delete();
    sb.delete();
    #1 check("req_valid_in_reset", imem_req_valid, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("deq_valid_after_reset", deq_valid, 0);
    check("deq_instr_after_reset", deq_instr, 0);
    check("deq_pc_after_reset", deq_pc, 0);
    cyc           = 0;
    exp_pc        = 32'h0;
    last_due      = -1;
    hs_cnt        = 0;
    pop_cnt       = 0;
    first_pop_cyc = -1;
    last_hs_cyc   = -1;
    first_pop_pc  = 32'hx;
    prev_stall    = 1'b0;
  endtask

  // One clock cycle: drive memory response, settle, score, advance.
  task automatic cycle();
    bit    resp;
    exp_t  e;
    mreq_t m;
    resp            = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_resp_valid = resp | spurious;
    imem_resp_data  = resp ? word_of(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    if (redirect) begin
      check("deq_valid_in_redirect", deq_valid, 0);
      check("req_valid_in_redirect", imem_req_valid, 0);
    end else if (prev_stall) begin
      check("req_valid_held", imem_req_valid, 1);
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_pc);
      e.pc    = exp_pc;
      e.instr = word_of(exp_pc);
      sb.push_back(e);
      m.addr   = exp_pc;
      m.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = m.due;
      mq.push_back(m);
      exp_pc      = exp_pc + 32'd4;
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (deq_valid && deq_ready) begin
      check("pop_has_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("deq_pc", deq_pc, e.pc);
        check("deq_instr", deq_instr, e.instr);
      end
      if (first_pop_cyc < 0) begin
        first_pop_cyc = cyc;
        first_pop_pc  = deq_pc;
      end
      pop_cnt++;
    end
    prev_stall = imem_req_valid & ~imem_req_ready;
    if (resp) void'(mq.pop_front());
    if (redirect) begin
      sb.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    deq_ready       = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    @(negedge clk);

    // Streaming with 1-cycle memory.
    do_reset();
    run(20);
    check("s1_handshakes", hs_cnt, 20);
    check("s1_first_pop_cyc", first_pop_cyc, 2);
    check("s1_pops", pop_cnt, 18);

    // Back-pressure fills the queue, then resumes.
    do_reset();
    deq_ready = 1'b0;
    run(10);
    check("s2_handshakes_full", hs_cnt, 4);
    check("s2_last_hs_cyc", last_hs_cyc, 3);
    check("s2_req_valid_full", imem_req_valid, 0);
    check("s2_deq_valid_full", deq_valid, 1);
    deq_ready = 1'b1;
    run(1);
    check("s2_no_req_on_pop", hs_cnt, 4);
    run(1);
    check("s2_resume", hs_cnt, 5);
    check("s2_resume_cyc", last_hs_cyc, first_pop_cyc + 1);
    run(10);

    // Redirect with three requests outstanding on 4-cycle memory.
    do_reset();
    lat = 4;
    run(3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    run(1);
    redirect = 1'b0;
    run(20);
    check("s3_first_deq_pc", first_pop_pc, 32'h0000_0100);
    check("s3_pops_seen", pop_cnt >= 3, 1);

    // Redirect coinciding with a response and a ready head.
    do_reset();
    run(3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    run(1);
    redirect = 1'b0;
    base     = pop_cnt;
    check("s4_pops_before", base, 1);
    run(8);
    check("s4_pops_after", pop_cnt - base, 6);

    // Fetch PC wraps past 0xFFFF_FFFC.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    run(1);
    redirect = 1'b0;
    run(10);
    check("s5_first_deq_pc", first_pop_pc, 32'hFFFF_FFF8);
    check("s5_handshakes", hs_cnt, 10);

    // Spurious responses into an empty queue.
    do_reset();
    imem_req_ready = 1'b0;
    spurious       = 1'b1;
    run(2);
    spurious = 1'b0;
    run(2);
    check("s6_deq_valid_empty", deq_valid, 0);
    check("s6_req_valid_stalled", imem_req_valid, 1);
    imem_req_ready = 1'b1;
    run(6);
    check("s6_first_deq_pc", first_pop_pc, 32'h0);
    check("s6_pops", pop_cnt, 4);

    // Randomized latency, back-pressure and redirects.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lat            = $urandom_range(1, 3);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      deq_ready      = ($urandom_range(0, 3) != 0);
      redirect       = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    deq_ready      = 1'b1;
    run(20);
    check("rnd_pops_seen", pop_cnt > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
